fighter_motion: RTL
===================

# fighter_motion

Parametrised per-fighter motion controller for the game controller object layer: one instance per fighter (player or enemy), configured by parameters rather than separate modules. It tracks horizontal position with clamping, a ground/airborne vertical state with a parabolic jump, squat and defend posture flags, and hit reaction. Hit reaction is knockback plus a hitstun window in which movement input is ignored. Outputs feed the renderer and the collision/damage logic each frame tick.

## Interface
- X_INIT, MAP_X - PLAYER_X: reset x position.
- X_MIN, MAP_X - LIMIT_X: lower x clamp (inclusive).
- X_MAX, MAP_X - PLAYER_X: upper x clamp (inclusive).
- GROUND_Y, -MAP_Y + PLAYER_Y: ground y position.
- STEP_X, game_param STEP_X: x step per cycle under left/right.
- V, game_param V: jump launch velocity. Requires (V << G_SHIFT) + 1 <= 255.
- G_SHIFT, 2: gravity shift; height term is (Jcnt*Jcnt) >>> G_SHIFT.
- KNOCK_X, 16: per-cycle knockback during hitstun.
- HITSTUN, 12: hitstun length in cycles, 1..255.
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- right, left, jump, squat, defend  in  1 each  level commands, sampled every posedge.
- hit  in  1  single-cycle hit strobe from damage logic.
- hit_dir  in  1  knockback direction: 1 = toward +x, 0 = toward -x.
- x  out  11 signed  fighter x.
- y  out  10 signed  fighter y.
- isD, isQ, isJ, isH  out  1 each  defending, squatting, airborne, in hitstun.

## Operation
- State is held in registers: x, y, vertical FSM {GROUND, AIR}, Jcnt (8 bits), stun counter Hcnt (8 bits). isH = (Hcnt != 0).
- Horizontal next value, computed from the current registers:
  - If Hcnt != 0: x ± KNOCK_X according to hit_dir, which is latched when the hit is taken.
  - Else if right: x + STEP_X. Else if left: x - STEP_X. right wins when both are high.
  - In all cases the result is clamped to [X_MIN, X_MAX] and computed at 12-bit signed width before clamping.
- Hit handling, on hit:
  - If defend=1 and the fighter is grounded and not stunned: blocked. x is pushed once by KNOCK_X>>1 in hit_dir (clamped), and Hcnt is unchanged.
  - Otherwise: Hcnt := HITSTUN and hit_dir is latched. A hit during hitstun reloads Hcnt and re-latches hit_dir.
  - Hcnt decrements by 1 per cycle while nonzero.
- Vertical FSM:
  - GROUND: y = GROUND_Y. If jump=1 and Hcnt=0, go to AIR with Jcnt := 0. jump during hitstun is ignored.
  - AIR: h = V*Jcnt - ((Jcnt*Jcnt) >>> G_SHIFT), computed at 20-bit signed width.
    - If h < 0: y := GROUND_Y, Jcnt := 0, go to GROUND.
    - Else: y := GROUND_Y + h and Jcnt++.
  - Hitstun does not interrupt the jump arc.
- Posture flags:
  - isJ = (state == AIR).
  - isQ = squat & GROUND & ~isH.
  - isD = defend & GROUND & ~isH.
  - If jump and squat are both high on the ground, the jump is taken and isQ stays 0 from the next cycle.

## Timing
- All outputs are registered. A command sampled at posedge k is visible after posedge k.
- Reset values: x = X_INIT, y = GROUND_Y, GROUND, Jcnt = 0, Hcnt = 0, isJ/isQ/isD/isH = 0.
- Jump timeline:
  - jump at edge k sets isJ; y stays GROUND_Y through edge k+1 (h(0) = 0).
  - Landing happens at the first edge where h < 0; isJ falls at that edge.
  - With V=8, G_SHIFT=2: apex h=64 at Jcnt=16, landing at Jcnt=33, isJ high for 34 cycles.
- hit at edge k: isH is high for exactly HITSTUN cycles (edges k .. k+HITSTUN-1 update to nonzero), and knockback is applied on each of those edges.
- A jump request on the same edge as the hit is ignored.
- Asserting reset mid-jump or mid-stun immediately forces the reset values. There is no resumption after reset.

## Configuration
- FIGHTER_AIR_CTRL_EN defined: left/right move x while in AIR, same as on the ground.
- Undefined: x holds while in AIR and Hcnt=0. Knockback still applies while airborne.

## Test plan
- Reset, then right held for 10 cycles with STEP_X=8 and X_INIT=X_MAX-40 -> x rises by 8 per cycle, saturates at X_MAX, and stays there. right+left together -> moves right.
- jump pulse on ground, V=8, G_SHIFT=2 -> isJ high for 34 cycles, peak y = GROUND_Y+64, and y returns exactly to GROUND_Y. A second jump pulse while in AIR has no effect.
- Undefended hit with hit_dir=0, KNOCK_X=16, HITSTUN=12 -> isH high for 12 cycles, x drops by 16 per cycle (clamped at X_MIN), and right/jump are ignored throughout.
- defend=1 on ground plus hit with hit_dir=1 -> x rises by 8 once, isH stays 0, isD stays 1. The same hit while airborne -> full hitstun.
- squat+jump on ground -> jump taken, isQ=0 throughout. right held in AIR -> x moves only when FIGHTER_AIR_CTRL_EN is defined.
- rst_n asserted at Jcnt=10 with isH high -> all outputs take their reset values asynchronously, and motion restarts cleanly after release.

Source files
------------

// File: rtl/fighter_motion.sv
// Per-fighter motion controller: clamped x with knockback/hitstun, ground/air jump arc, posture flags.
// Optional FIGHTER_AIR_CTRL_EN lets left/right steer while airborne.
module fighter_motion #(
  parameter int X_INIT   = 560,
  parameter int X_MIN    = 16,
  parameter int X_MAX    = 600,
  parameter int GROUND_Y = -100,
  parameter int STEP_X   = 8,
  parameter int V        = 8,
  parameter int G_SHIFT  = 2,
  parameter int KNOCK_X  = 16,
  parameter int HITSTUN  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               right,
  input  logic               left,
  input  logic               jump,
  input  logic               squat,
  input  logic               defend,
  input  logic               hit,
  input  logic               hit_dir,
  output logic signed [10:0] x,
  output logic signed [9:0]  y,
  output logic               isD,
  output logic               isQ,
  output logic               isJ,
  output logic               isH
);
  typedef enum logic {GROUND, AIR} vstate_t;

  localparam logic signed [11:0] XMIN12  = 12'(X_MIN);
  localparam logic signed [11:0] XMAX12  = 12'(X_MAX);
  localparam logic signed [10:0] XMIN11  = 11'(X_MIN);
  localparam logic signed [10:0] XMAX11  = 11'(X_MAX);
  localparam logic signed [10:0] XINIT11 = 11'(X_INIT);
  localparam logic signed [9:0]  GY10    = 10'(GROUND_Y);
  localparam logic signed [11:0] STEP12  = 12'(STEP_X);
  localparam logic signed [11:0] KNOCK12 = 12'(KNOCK_X);
  localparam logic signed [11:0] PUSH12  = 12'(KNOCK_X >> 1);
  localparam logic signed [19:0] V20     = 20'(V);
  localparam logic [7:0]         STUN8   = 8'(HITSTUN);

  vstate_t                state, state_nxt;
  logic [7:0]             jcnt, jcnt_nxt, hcnt, hcnt_nxt;
  logic                   hdir, kdir;
  logic signed [9:0]      y_nxt;
  logic signed [10:0]     x_nxt;
  logic signed [11:0]     dx, x_sum;
  logic signed [19:0]     j20, h;
  logic                   blocked, taken, move_ok;

`ifdef FIGHTER_AIR_CTRL_EN
  assign move_ok = 1'b1;
`else
  assign move_ok = (state == GROUND);
`endif

  // A defended hit only counts as blocked when grounded and not already reeling.
  assign blocked  = hit & defend & (state == GROUND) & (hcnt == 8'd0);
  assign taken    = hit & ~blocked;
  assign hcnt_nxt = taken ? STUN8 : ((hcnt != 8'd0) ? hcnt - 8'd1 : 8'd0);
  assign kdir     = taken ? hit_dir : hdir;

  assign j20 = {12'd0, jcnt};
  assign h   = (V20 * j20) - ((j20 * j20) >>> G_SHIFT);

  // Knockback fires on every edge that leaves the stun counter nonzero.
  always_comb begin
    dx = '0;
    if (hcnt_nxt != 8'd0)
      dx = kdir ? KNOCK12 : -KNOCK12;
    else if (blocked)
      dx = hit_dir ? PUSH12 : -PUSH12;
    else if (hcnt == 8'd0 && move_ok) begin
      if (right)     dx = STEP12;
      else if (left) dx = -STEP12;
    end
    x_sum = {x[10], x} + dx;
    if (x_sum < XMIN12)      x_nxt = XMIN11;
    else if (x_sum > XMAX12) x_nxt = XMAX11;
    else                     x_nxt = 11'(x_sum);
  end

  always_comb begin
    state_nxt = state;
    jcnt_nxt  = jcnt;
    y_nxt     = y;
    case (state)
      GROUND: begin
        y_nxt = GY10;
        if (jump && hcnt == 8'd0 && !hit) begin
          state_nxt = AIR;
          jcnt_nxt  = 8'd0;
        end
      end
      AIR: begin
        if (h < 0) begin
          state_nxt = GROUND;
          jcnt_nxt  = 8'd0;
          y_nxt     = GY10;
        end else begin
          jcnt_nxt = jcnt + 8'd1;
          y_nxt    = GY10 + h[9:0];
        end
      end
      default: state_nxt = GROUND;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GROUND;
      jcnt  <= 8'd0;
      hcnt  <= 8'd0;
      hdir  <= 1'b0;
      x     <= XINIT11;
      y     <= GY10;
      isD   <= 1'b0;
      isQ   <= 1'b0;
    end else begin
      state <= state_nxt;
      jcnt  <= jcnt_nxt;
      hcnt  <= hcnt_nxt;
      if (taken) hdir <= hit_dir;
      x     <= x_nxt;
      y     <= y_nxt;
      isD   <= defend & (state_nxt == GROUND) & (hcnt_nxt == 8'd0);
      isQ   <= squat  & (state_nxt == GROUND) & (hcnt_nxt == 8'd0);
    end
  end

  assign isJ = (state == AIR);
  assign isH = (hcnt != 8'd0);

endmodule
